// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the digit-serial adder.
package serial_adder_pkg;

  // Operation sequencing: waiting, adding slices, presenting a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits consumed per clock when the instantiator does not choose.
  localparam int DEFAULT_DIGIT = 4;

endpackage

// File: rtl/serial_adder_slice.sv
// DIGIT-bit combinational ripple adder built from full-adder bit cells.
// cmsb exposes the carry into the top bit so the caller can form signed
// overflow on the most significant slice.
module adder_slice
  import serial_adder_pkg::*;
#(
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]       = x[i] ^ y[i] ^ c_s[i];
    assign c_s[i + 1] = (x[i] & y[i]) | (c_s[i] & (x[i] ^ y[i]));
  end

  assign cout = c_s[DIGIT];
  assign cmsb = c_s[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock, LSB first.
// Subtraction is a + ~b + 1, so carryout=1 means "no borrow".
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = DEFAULT_DIGIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

  state_t           state_r;
  state_t           state_nx_s;
  logic             accept_s;
  logic             last_s;

  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic [WIDTH-1:0] res_r;
  logic             carry_r;
  logic             carryout_r;
  logic             overflow_r;
  logic [CW-1:0]    cnt_r;

  logic [DIGIT-1:0] sum_s;
  logic             cout_s;
  logic             cmsb_s;
  logic [WIDTH-1:0] opa_nx_s;
  logic [WIDTH-1:0] opb_nx_s;
  logic [WIDTH-1:0] res_nx_s;

  // Only the lowest unprocessed slice of each operand feeds the adder.
  adder_slice #(.DIGIT(DIGIT)) u_slice (
    .x    (opa_r[DIGIT-1:0]),
    .y    (opb_r[DIGIT-1:0]),
    .cin  (carry_r),
    .s    (sum_s),
    .cout (cout_s),
    .cmsb (cmsb_s)
  );

  // Operands shift down one slice; slice sums enter the result from the top.
  if (DIGIT == WIDTH) begin : g_single
    assign opa_nx_s = '0;
    assign opb_nx_s = '0;
    assign res_nx_s = sum_s;
  end else begin : g_multi
    assign opa_nx_s = {{DIGIT{1'b0}}, opa_r[WIDTH-1:DIGIT]};
    assign opb_nx_s = {{DIGIT{1'b0}}, opb_r[WIDTH-1:DIGIT]};
    assign res_nx_s = {sum_s, res_r[WIDTH-1:DIGIT]};
  end

  assign last_s = (cnt_r == LAST_CNT);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode; start is only honoured outside RUN.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = RUN;
          accept_s   = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_nx_s = RUN;
          accept_s   = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // Datapath: load on accept, consume one slice per RUN cycle, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opa_r      <= '0;
      opb_r      <= '0;
      res_r      <= '0;
      carry_r    <= 1'b0;
      carryout_r <= 1'b0;
      overflow_r <= 1'b0;
      cnt_r      <= '0;
    end else if (accept_s) begin
      opa_r   <= a;
      opb_r   <= b ^ {WIDTH{sub}};
      carry_r <= sub;
      cnt_r   <= '0;
    end else if (state_r == RUN) begin
      opa_r      <= opa_nx_s;
      opb_r      <= opb_nx_s;
      res_r      <= res_nx_s;
      carry_r    <= cout_s;
      carryout_r <= cout_s;
      overflow_r <= cout_s ^ cmsb_s;
      cnt_r      <= cnt_r + 1'b1;
    end
  end

  assign busy     = (state_r == RUN);
  assign done     = (state_r == DONE);
  assign result   = res_r;
  assign carryout = carryout_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder, WIDTH=8 with DIGIT in {1,2,4,8}.
module tb_serial_adder;

  typedef struct {
    int         sel;
    logic [7:0] res;
    logic       co;
    logic       ov;
    int         t;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] start_v;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy_w [4];
  logic       done_w [4];
  logic [7:0] res_w  [4];
  logic       co_w   [4];
  logic       ov_w   [4];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   free_at [4];
  exp_t sb [$];
  exp_t mon_e;
  logic [7:0] last_res [4];
  logic       last_co  [4];
  logic       last_ov  [4];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_adder #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start_v[g]),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .busy     (busy_w[g]),
      .done     (done_w[g]),
      .result   (res_w[g]),
      .carryout (co_w[g]),
      .overflow (ov_w[g])
    );
  end

  function automatic int lat(input int sel);
    return 8 >> sel;
  endfunction

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input int sel, input logic [7:0] x, input logic [7:0] y,
                                 input logic s, input int t);
    exp_t m;
    int ux, uy, sx, sy, ur, sr;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    ur = s ? (ux - uy) : (ux + uy);
    sr = s ? (sx - sy) : (sx + sy);
    m.sel = sel;
    m.res = 8'(ur);
    m.co  = s ? (ux >= uy) : (ur > 255);
    m.ov  = (sr > 127) || (sr < -128);
    m.t   = t;
    return m;
  endfunction

  task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d]: actual %0h, required %0h", name, g, act, exp);
    end
  endtask

  // Accept happens on the coming edge with whatever a/b/sub are driven now.
  task automatic accept_now(input int sel, input bit hold);
    exp_t e;
    @(posedge clk);
    #1;
    e = model(sel, a, b, sub, cyc);
    sb.push_back(e);
    chk("busy_after_accept", sel, busy_w[sel], 1);
    chk("done_after_accept", sel, done_w[sel], 0);
    free_at[sel] = cyc + lat(sel);
    if (!hold) start_v[sel] = 1'b0;
  endtask

  task automatic op(input int sel, input logic [7:0] ta, input logic [7:0] tb,
                    input logic ts, input bit hold);
    @(negedge clk);
    while (cyc < free_at[sel]) @(negedge clk);
    a = ta;
    b = tb;
    sub = ts;
    start_v[sel] = 1'b1;
    accept_now(sel, hold);
  endtask

  // Monitor: pops on every done, otherwise checks idle outputs are held.
  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) begin
        if (reset) begin
          last_res[g] = 8'h00;
          last_co[g]  = 1'b0;
          last_ov[g]  = 1'b0;
        end else if (done_w[g]) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done[dut%0d]: actual done=1, required done=0", g);
          end else begin
            mon_e = sb.pop_front();
            chk("sel", g, g, mon_e.sel);
            chk("result", g, res_w[g], mon_e.res);
            chk("carryout", g, co_w[g], mon_e.co);
            chk("overflow", g, ov_w[g], mon_e.ov);
            chk("latency", g, cyc - mon_e.t, lat(g));
            chk("busy_at_done", g, busy_w[g], 0);
            last_res[g] = mon_e.res;
            last_co[g]  = mon_e.co;
            last_ov[g]  = mon_e.ov;
          end
        end else if (!busy_w[g]) begin
          chk("hold_result", g, res_w[g], last_res[g]);
          chk("hold_carryout", g, co_w[g], last_co[g]);
          chk("hold_overflow", g, ov_w[g], last_ov[g]);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit prev_hold;
    reset = 1'b1;
    start_v = 4'b0000;
    sub = 1'b0;
    a = 8'h00;
    b = 8'h00;
    for (int g = 0; g < 4; g++) free_at[g] = 0;

    repeat (2) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk("reset_busy", g, busy_w[g], 0);
      chk("reset_done", g, done_w[g], 0);
      chk("reset_result", g, res_w[g], 0);
      chk("reset_carryout", g, co_w[g], 0);
      chk("reset_overflow", g, ov_w[g], 0);
    end
    #2 reset = 1'b0;

    // Directed cases on the DIGIT=4 instance.
    op(2, 8'hFF, 8'h01, 1'b0, 1'b0);
    op(2, 8'h7F, 8'h01, 1'b0, 1'b0);
    op(2, 8'h05, 8'h07, 1'b1, 1'b0);
    op(2, 8'h80, 8'h01, 1'b1, 1'b0);

    // Back-to-back with start held through RUN and DONE.
    op(2, 8'h33, 8'h44, 1'b0, 1'b1);
    op(2, 8'h10, 8'h20, 1'b0, 1'b0);

    // Start pulsed during RUN with different operands must be ignored.
    op(2, 8'h11, 8'h22, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'hAA;
    b = 8'h55;
    start_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;

    // Reset one cycle after accept; start held during reset is ignored,
    // then the first edge after release accepts.
    op(2, 8'h12, 8'h34, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrun_reset_busy", 2, busy_w[2], 0);
    chk("midrun_reset_done", 2, done_w[2], 0);
    chk("midrun_reset_result", 2, res_w[2], 0);
    chk("midrun_reset_carryout", 2, co_w[2], 0);
    chk("midrun_reset_overflow", 2, ov_w[2], 0);
    sb.delete();
    for (int g = 0; g < 4; g++) free_at[g] = 0;
    a = 8'h7F;
    b = 8'h7F;
    sub = 1'b0;
    start_v[2] = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    accept_now(2, 1'b0);
    op(2, 8'hC0, 8'h40, 1'b1, 1'b0);

    // Random regression on every DIGIT, with random back-to-back holds.
    for (int s = 0; s < 4; s++) begin
      prev_hold = 1'b0;
      for (int k = 0; k < 30; k++) begin
        bit h;
        h = 1'($urandom_range(0, 1));
        if (!prev_hold) repeat ($urandom_range(0, 3)) @(negedge clk);
        op(s, 8'($urandom), 8'($urandom), 1'($urandom), h);
        prev_hold = h;
      end
      start_v[s] = 1'b0;
      while (cyc < free_at[s] + 2) @(negedge clk);
    end

    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drain", 0, sb.size(), 0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
